// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard-detection unit beside ID: tracks the last FWD_DEPTH destinations,
// produces EXE/MEM bypass selects, ID compare selects and load-use/branch stalls (optional FWD_PERF_CNT_EN counters).
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 3,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_store,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_load,
    input  logic                  id_branch_cmp,
    input  logic                  flush,
    output logic [SEL_W-1:0]      exe_a_sel,
    output logic [SEL_W-1:0]      exe_b_sel,
    output logic [SEL_W-1:0]      mem_data_sel,
    output logic [SEL_W-1:0]      br_a_sel,
    output logic [SEL_W-1:0]      br_b_sel,
`ifdef FWD_PERF_CNT_EN
    output logic                  stall,
    output logic [31:0]           stall_count,
    output logic [31:0]           fwd_count
`else
    output logic                  stall
`endif
);

    // Entry 0 is the instruction in EXE; only the two youngest load flags can cause a stall.
    logic [FWD_DEPTH-1:0]  hist_vld_p0;
    logic [REG_ADDR_W-1:0] hist_dest_p0 [FWD_DEPTH];
    logic [1:0]            hist_load_p0;

    logic [FWD_DEPTH-1:0]  m_rs;
    logic [FWD_DEPTH-1:0]  m_rt;
    logic [SEL_W-1:0]      rs_sel;
    logic [SEL_W-1:0]      rt_sel;
    logic [SEL_W-1:0]      exe_b_nxt;
    logic [SEL_W-1:0]      mem_nxt;
    logic                  stall_lu;
    logic                  stall_br;
    logic                  advance;

    function automatic logic [SEL_W-1:0] youngest_sel(input logic [FWD_DEPTH-1:0] m);
        logic [SEL_W-1:0] s;
        s = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (m[k]) s = SEL_W'(k + 1);
        end
        return s;
    endfunction

    for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_match
        assign m_rs[k] = id_rs_used && hist_vld_p0[k] && (hist_dest_p0[k] == id_rs) && (id_rs != '0);
        assign m_rt[k] = id_rt_used && hist_vld_p0[k] && (hist_dest_p0[k] == id_rt) && (id_rt != '0);
    end

    // ID stage: combinational selects and stall
    always_comb begin
        rs_sel    = youngest_sel(m_rs);
        rt_sel    = youngest_sel(m_rt);
        exe_b_nxt = id_store ? '0 : rt_sel;
        mem_nxt   = id_store ? rt_sel : '0;
        // Store data can take a loaded value straight from the load in EXE, so it never stalls.
        stall_lu  = id_valid && !id_branch_cmp && hist_load_p0[0] &&
                    (m_rs[0] || (m_rt[0] && !id_store));
        stall_br  = id_valid && id_branch_cmp &&
                    (m_rs[0] || m_rt[0] || (hist_load_p0[1] && (m_rs[1] || m_rt[1])));
        stall     = stall_lu || stall_br;
        advance   = id_valid && !stall && !flush;
        br_a_sel  = rs_sel;
        br_b_sel  = rt_sel;
    end

    // ID -> EXE boundary: history shift and registered selects
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hist_vld_p0  <= '0;
            exe_a_sel    <= '0;
            exe_b_sel    <= '0;
            mem_data_sel <= '0;
        end else begin
            hist_vld_p0  <= {hist_vld_p0[FWD_DEPTH-2:0], advance && id_reg_write};
            exe_a_sel    <= advance ? rs_sel    : '0;
            exe_b_sel    <= advance ? exe_b_nxt : '0;
            mem_data_sel <= advance ? mem_nxt   : '0;
        end
    end

    always_ff @(posedge CLK) begin
        hist_dest_p0[0] <= id_dest;
        for (int k = 1; k < FWD_DEPTH; k++) begin
            hist_dest_p0[k] <= hist_dest_p0[k-1];
        end
        hist_load_p0 <= {hist_load_p0[0], id_load};
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall) stall_count <= stall_count + 32'd1;
            if (advance && ((rs_sel != '0) || (rt_sel != '0))) fwd_count <= fwd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit at default parameters (REG_ADDR_W=5, FWD_DEPTH=3).
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int SW = 2;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          id_valid, id_rs_used, id_rt_used, id_store, id_reg_write, id_load, id_branch_cmp, flush;
    logic [AW-1:0] id_rs, id_rt, id_dest;
    logic [SW-1:0] exe_a_sel, exe_b_sel, mem_data_sel, br_a_sel, br_b_sel;
    logic          stall;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]   stall_count, fwd_count;
    logic [31:0]   sc_before;
`endif

    int n_pass  = 0;
    int n_total = 0;

    fwd_hazard_unit dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_store     (id_store),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_load      (id_load),
        .id_branch_cmp(id_branch_cmp),
        .flush        (flush),
        .exe_a_sel    (exe_a_sel),
        .exe_b_sel    (exe_b_sel),
        .mem_data_sel (mem_data_sel),
        .br_a_sel     (br_a_sel),
        .br_b_sel     (br_b_sel),
`ifdef FWD_PERF_CNT_EN
        .stall        (stall),
        .stall_count  (stall_count),
        .fwd_count    (fwd_count)
`else
        .stall        (stall)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic rsu, input logic rtu, input logic st,
                          input logic [AW-1:0] dest, input logic rw, input logic ld, input logic br);
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_store = st; id_dest = dest; id_reg_write = rw; id_load = ld; id_branch_cmp = br;
        flush = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RESET_N = 1'b0;
        #1;
        n_total++; if (exe_a_sel !== 2'd0) $display("FAIL reset_exe_a: got %0d want 0", exe_a_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd0) $display("FAIL reset_exe_b: got %0d want 0", exe_b_sel); else n_pass++;
        n_total++; if (mem_data_sel !== 2'd0) $display("FAIL reset_mem: got %0d want 0", mem_data_sel); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %0d want 0", stall); else n_pass++;
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        step();
        // build up history, then reset in the middle of a cycle
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); step();
        set_id(1, 3, 0, 1, 0, 0, 9, 1, 0, 0); step();
        n_total++; if (exe_a_sel !== 2'd1) $display("FAIL pre_reset_exe_a: got %0d want 1", exe_a_sel); else n_pass++;
        set_id(1, 9, 3, 1, 1, 0, 10, 1, 1, 0);
        #2;
        RESET_N = 1'b0;
        #1;
        n_total++; if (exe_a_sel !== 2'd0) $display("FAIL midreset_exe_a: got %0d want 0", exe_a_sel); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL midreset_stall: got %0d want 0", stall); else n_pass++;
        set_id(1, 3, 9, 1, 1, 0, 0, 0, 0, 1);
        #1;
        n_total++; if (br_a_sel !== 2'd0) $display("FAIL midreset_br_a: got %0d want 0", br_a_sel); else n_pass++;
        n_total++; if (br_b_sel !== 2'd0) $display("FAIL midreset_br_b: got %0d want 0", br_b_sel); else n_pass++;
        RESET_N = 1'b1;
        set_id(1, 3, 9, 1, 1, 0, 11, 1, 0, 0); step();
        n_total++; if (exe_a_sel !== 2'd0) $display("FAIL postreset_exe_a: got %0d want 0", exe_a_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd0) $display("FAIL postreset_exe_b: got %0d want 0", exe_b_sel); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drain();
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); step();
        set_id(1, 3, 3, 1, 1, 0, 4, 1, 0, 0);
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL b2b_stall: got %0d want 0", stall); else n_pass++;
        step();
        n_total++; if (exe_a_sel !== 2'd1) $display("FAIL b2b_d1_exe_a: got %0d want 1", exe_a_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd1) $display("FAIL b2b_d1_exe_b: got %0d want 1", exe_b_sel); else n_pass++;
        n_total++; if (mem_data_sel !== 2'd0) $display("FAIL b2b_d1_mem: got %0d want 0", mem_data_sel); else n_pass++;
        // one unrelated instruction in between
        drain();
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); step();
        set_id(1, 11, 12, 1, 1, 0, 10, 1, 0, 0); step();
        set_id(1, 3, 3, 1, 1, 0, 4, 1, 0, 0); step();
        n_total++; if (exe_a_sel !== 2'd2) $display("FAIL b2b_d2_exe_a: got %0d want 2", exe_a_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd2) $display("FAIL b2b_d2_exe_b: got %0d want 2", exe_b_sel); else n_pass++;
        // two unrelated instructions in between
        drain();
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); step();
        set_id(1, 11, 12, 1, 1, 0, 10, 1, 0, 0); step();
        set_id(1, 13, 14, 1, 1, 0, 15, 1, 0, 0); step();
        set_id(1, 3, 3, 1, 1, 0, 4, 1, 0, 0); step();
        n_total++; if (exe_a_sel !== 2'd3) $display("FAIL b2b_d3_exe_a: got %0d want 3", exe_a_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd3) $display("FAIL b2b_d3_exe_b: got %0d want 3", exe_b_sel); else n_pass++;
        // producer beyond the tracked depth comes from the register file
        drain();
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); step();
        set_id(1, 11, 12, 1, 1, 0, 10, 1, 0, 0); step();
        set_id(1, 13, 14, 1, 1, 0, 15, 1, 0, 0); step();
        set_id(1, 16, 17, 1, 1, 0, 18, 1, 0, 0); step();
        set_id(1, 3, 3, 1, 1, 0, 4, 1, 0, 0); step();
        n_total++; if (exe_a_sel !== 2'd0) $display("FAIL b2b_d4_exe_a: got %0d want 0", exe_a_sel); else n_pass++;
        // youngest producer wins; unused source never forwards
        drain();
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); step();
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); step();
        set_id(1, 3, 3, 1, 0, 0, 4, 1, 0, 0); step();
        n_total++; if (exe_a_sel !== 2'd1) $display("FAIL youngest_exe_a: got %0d want 1", exe_a_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd0) $display("FAIL unused_rt_exe_b: got %0d want 0", exe_b_sel); else n_pass++;
    endtask

    task automatic test_load_use();
        drain();
        set_id(1, 1, 0, 1, 0, 0, 5, 1, 1, 0); step();
        set_id(1, 5, 6, 1, 1, 0, 8, 1, 0, 0);
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL lu_stall_c0: got %0d want 1", stall); else n_pass++;
        step();
        n_total++; if (stall !== 1'b0) $display("FAIL lu_stall_c1: got %0d want 0", stall); else n_pass++;
        n_total++; if (exe_a_sel !== 2'd0) $display("FAIL lu_bubble_exe_a: got %0d want 0", exe_a_sel); else n_pass++;
        step();
        n_total++; if (exe_a_sel !== 2'd2) $display("FAIL lu_exe_a: got %0d want 2", exe_a_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd0) $display("FAIL lu_exe_b: got %0d want 0", exe_b_sel); else n_pass++;
        // load followed by an ALU op reading the loaded value through rt
        drain();
        set_id(1, 1, 0, 1, 0, 0, 4, 1, 1, 0); step();
        set_id(1, 1, 4, 1, 1, 0, 8, 1, 0, 0);
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL lu_rt_stall: got %0d want 1", stall); else n_pass++;
        step();
    endtask

    task automatic test_branch();
        drain();
        set_id(1, 1, 2, 1, 1, 0, 7, 1, 0, 0); step();
        set_id(1, 7, 0, 1, 1, 0, 0, 0, 0, 1);
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL br_alu_stall_c0: got %0d want 1", stall); else n_pass++;
        step();
        n_total++; if (stall !== 1'b0) $display("FAIL br_alu_stall_c1: got %0d want 0", stall); else n_pass++;
        n_total++; if (br_a_sel !== 2'd2) $display("FAIL br_alu_br_a: got %0d want 2", br_a_sel); else n_pass++;
        n_total++; if (br_b_sel !== 2'd0) $display("FAIL br_alu_br_b: got %0d want 0", br_b_sel); else n_pass++;
        step();
        // load producer needs two stall cycles
        drain();
        set_id(1, 1, 0, 1, 0, 0, 7, 1, 1, 0); step();
        set_id(1, 2, 7, 1, 1, 0, 0, 0, 0, 1);
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL br_ld_stall_c0: got %0d want 1", stall); else n_pass++;
        step();
        n_total++; if (stall !== 1'b1) $display("FAIL br_ld_stall_c1: got %0d want 1", stall); else n_pass++;
        step();
        n_total++; if (stall !== 1'b0) $display("FAIL br_ld_stall_c2: got %0d want 0", stall); else n_pass++;
        n_total++; if (br_b_sel !== 2'd3) $display("FAIL br_ld_br_b: got %0d want 3", br_b_sel); else n_pass++;
        step();
    endtask

    task automatic test_store_and_r0();
        drain();
        set_id(1, 1, 0, 1, 0, 0, 4, 1, 1, 0); step();
        set_id(1, 1, 4, 1, 1, 1, 0, 0, 0, 0);
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL st_stall: got %0d want 0", stall); else n_pass++;
        step();
        n_total++; if (mem_data_sel !== 2'd1) $display("FAIL st_mem: got %0d want 1", mem_data_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd0) $display("FAIL st_exe_b: got %0d want 0", exe_b_sel); else n_pass++;
        n_total++; if (exe_a_sel !== 2'd0) $display("FAIL st_exe_a: got %0d want 0", exe_a_sel); else n_pass++;
        // r0 in history never forwards or stalls
        drain();
        set_id(1, 1, 0, 1, 0, 0, 0, 1, 1, 0); step();
        set_id(1, 0, 0, 1, 1, 0, 6, 1, 0, 0);
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL r0_stall: got %0d want 0", stall); else n_pass++;
        step();
        n_total++; if (exe_a_sel !== 2'd0) $display("FAIL r0_exe_a: got %0d want 0", exe_a_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd0) $display("FAIL r0_exe_b: got %0d want 0", exe_b_sel); else n_pass++;
    endtask

    task automatic test_flush();
        drain();
        set_id(1, 1, 0, 1, 0, 0, 5, 1, 1, 0); step();
        set_id(1, 5, 6, 1, 1, 0, 8, 1, 0, 0);
        flush = 1'b1;
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL fl_stall: got %0d want 1", stall); else n_pass++;
`ifdef FWD_PERF_CNT_EN
        sc_before = stall_count;
`endif
        step();
        n_total++; if (exe_a_sel !== 2'd0) $display("FAIL fl_bubble_exe_a: got %0d want 0", exe_a_sel); else n_pass++;
`ifdef FWD_PERF_CNT_EN
        n_total++; if (stall_count !== sc_before + 32'd1) $display("FAIL fl_stall_count: got %0d want %0d", stall_count, sc_before + 32'd1); else n_pass++;
`endif
        // the flushed writer of r8 must not appear in history
        set_id(1, 8, 5, 1, 1, 0, 11, 1, 0, 0);
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL fl_next_stall: got %0d want 0", stall); else n_pass++;
        step();
        n_total++; if (exe_a_sel !== 2'd0) $display("FAIL fl_next_exe_a: got %0d want 0", exe_a_sel); else n_pass++;
        n_total++; if (exe_b_sel !== 2'd2) $display("FAIL fl_next_exe_b: got %0d want 2", exe_b_sel); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_store_and_r0();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
